// File: rtl/mac_lane_array.sv
// Multi-lane sparse signed MAC array: accumulates k beats of masked lane products, then holds the result until it is taken.
// Define MAC_LANE_SAT_EN to saturate each lane on narrowing to OUT_W; otherwise the low OUT_W bits are kept (wrap).
module mac_lane_array #(
  parameter int LANES  = 32,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int K_MAX  = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(K_MAX+1)-1:0]    cfg_k,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_W-1:0]       in_a,
  input  logic [LANES*DATA_W-1:0]       in_b,
  input  logic [LANES-1:0]              in_mask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUT_W-1:0]        out_data,
  output logic                          busy
);
  localparam int K_W = $clog2(K_MAX+1);

  typedef enum logic [1:0] {IDLE, ACC, DRAIN} state_t;

  state_t                  state_reg;
  logic [K_W-1:0]          count_reg;
  logic [K_W-1:0]          k_reg;
  logic                    out_valid_reg;
  logic                    in_ready_reg;
  logic                    busy_reg;
  logic signed [ACC_W-1:0] acc_reg [LANES];
  logic signed [ACC_W-1:0] prod [LANES];
  logic [K_W-1:0]          k_first;
  logic [K_W-1:0]          count_next;

  // cfg_k of 0 means a single beat; anything above K_MAX is clamped.
  always_comb begin
    k_first = cfg_k;
    if (cfg_k == '0)
      k_first = K_W'(1);
    else if (cfg_k > K_W'(K_MAX))
      k_first = K_W'(K_MAX);
  end

  assign count_next = count_reg + K_W'(1);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [2*DATA_W-1:0] full;
      logic signed [OUT_W-1:0]    narrow;

      assign full     = $signed(in_a[gi*DATA_W +: DATA_W]) * $signed(in_b[gi*DATA_W +: DATA_W]);
      assign prod[gi] = in_mask[gi] ? ACC_W'(full) : '0;

`ifdef MAC_LANE_SAT_EN
      // In range only when every bit from OUT_W-1 upward matches the sign.
      logic [ACC_W-OUT_W:0] hi;
      assign hi = acc_reg[gi][ACC_W-1:OUT_W-1];
      always_comb begin
        narrow = acc_reg[gi][OUT_W-1:0];
        if (hi != '0 && hi != '1)
          narrow = acc_reg[gi][ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end
`else
      assign narrow = acc_reg[gi][OUT_W-1:0];
      if (OUT_W < ACC_W) begin : g_drop
        logic unused_hi;
        assign unused_hi = ^acc_reg[gi][ACC_W-1:OUT_W];
      end
`endif

      assign out_data[gi*OUT_W +: OUT_W] = out_valid_reg ? narrow : '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      k_reg         <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      for (int i = 0; i < LANES; i++) acc_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            k_reg     <= k_first;
            count_reg <= K_W'(1);
            busy_reg  <= 1'b1;
            for (int i = 0; i < LANES; i++) acc_reg[i] <= prod[i];
            if (k_first == K_W'(1)) begin
              state_reg     <= DRAIN;
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
            end else begin
              state_reg <= ACC;
            end
          end
        end
        ACC: begin
          if (in_valid) begin
            count_reg <= count_next;
            for (int i = 0; i < LANES; i++) acc_reg[i] <= acc_reg[i] + prod[i];
            if (count_next == k_reg) begin
              state_reg     <= DRAIN;
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
endmodule

// File: tb/tb_mac_lane_array.sv
// Self-checking bench for mac_lane_array (32 lanes, OUT_W=16, K_MAX=8) against a per-lane sum-of-products model.
// Lane narrowing expectations follow MAC_LANE_SAT_EN when it is defined for the build.
module tb_mac_lane_array;
  localparam int LANES = 32, DW = 16, AW = 40, OW = 16, KM = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        cfg_k = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LANES*DW-1:0] in_a = '0, in_b = '0;
  logic [LANES-1:0]  in_mask = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [LANES*OW-1:0] out_data;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic signed [DW-1:0] a_l [LANES];
  logic signed [DW-1:0] b_l [LANES];
  logic [LANES-1:0]     mask_v;
  longint               exp_sum [LANES];
  logic [LANES*OW-1:0]  exp_vec;
  logic [LANES*OW-1:0]  got;
  logic [OW-1:0]        lane;

  mac_lane_array #(.LANES(LANES), .DATA_W(DW), .ACC_W(AW), .OUT_W(OW), .K_MAX(KM)) dut (
    .clk(clk), .rst(rst), .cfg_k(cfg_k), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [LANES*OW-1:0] obs, input logic [LANES*OW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Wrap the exact sum into the 40-bit accumulator, then narrow to 16 bits.
  function automatic logic [OW-1:0] narrow(input longint s);
    longint w;
    w = (s <<< 24) >>> 24;
`ifdef MAC_LANE_SAT_EN
    if (w > 32767) return 16'h7FFF;
    if (w < -32768) return 16'h8000;
`endif
    return w[OW-1:0];
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        1: begin a_l[i] = 16'sd1; b_l[i] = 16'sd1; end
        2: begin a_l[i] = DW'(i); b_l[i] = -16'sd2; end
        3: begin a_l[i] = 16'sd32767; b_l[i] = 16'sd32767; end
        default: begin a_l[i] = DW'($urandom); b_l[i] = DW'($urandom); end
      endcase
    end
    case (mode)
      1, 3:    mask_v = '1;
      2:       mask_v = 32'h5555_5555;
      default: mask_v = $urandom;
    endcase
    for (int i = 0; i < LANES; i++) begin
      in_a[i*DW +: DW] = a_l[i];
      in_b[i*DW +: DW] = b_l[i];
    end
    in_mask = mask_v;
  endtask

  task automatic run_job(input int cfg, input int mode, input int gaps, input int stall,
                         input string tag, output logic [LANES*OW-1:0] snap);
    int k;
    k = (cfg == 0) ? 1 : ((cfg > KM) ? KM : cfg);
    for (int i = 0; i < LANES; i++) exp_sum[i] = 0;
    for (int bt = 0; bt < k; bt++) begin
      if (bt > 0) begin
        for (int g = 0; g < gaps; g++) begin
          in_valid = 1'b0;
          fill(0);
          cfg_k = 4'($urandom);
          @(posedge clk); #1;
          chk({tag, "_gap_busy"}, busy, 1);
          chk({tag, "_gap_out_valid"}, out_valid, 0);
        end
      end
      fill(mode);
      cfg_k = (bt == 0) ? 4'(cfg) : 4'($urandom_range(0, 15));
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_early_valid"}, out_valid, 0);
      for (int i = 0; i < LANES; i++)
        if (mask_v[i]) exp_sum[i] += longint'(a_l[i]) * longint'(b_l[i]);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    for (int i = 0; i < LANES; i++) exp_vec[i*OW +: OW] = narrow(exp_sum[i]);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_drain_ready"}, in_ready, 0);
    chk({tag, "_drain_busy"}, busy, 1);
    chk_vec({tag, "_data"}, out_data, exp_vec);
    snap = out_data;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, out_valid, 1);
      chk({tag, "_stall_ready"}, in_ready, 0);
      chk_vec({tag, "_stall_data"}, out_data, exp_vec);
    end
    // Offer a beat on the handshake cycle; it must not be taken.
    out_ready = 1'b1;
    in_valid = 1'b1;
    fill(0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_done_valid"}, out_valid, 0);
    chk({tag, "_done_ready"}, in_ready, 1);
    chk({tag, "_done_busy"}, busy, 0);
    chk_vec({tag, "_idle_data"}, out_data, '0);
    @(posedge clk); #1;
    chk({tag, "_no_extra_beat"}, busy, 0);
    $display("job %s cfg_k=%0d k=%0d gaps=%0d stall=%0d lane0=%0h", tag, cfg, k, gaps, stall, exp_vec[OW-1:0]);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk_vec("rst_data", out_data, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    chk_vec("post_rst_data", out_data, '0);

    run_job(4, 1, 0, 0, "ones_k4", got);
    lane = got[0 +: OW];            chk("ones_lane0", lane, 16'd4);
    lane = got[31*OW +: OW];        chk("ones_lane31", lane, 16'd4);

    run_job(3, 2, 2, 0, "sparse_k3", got);
    lane = got[6*OW +: OW];         chk("sparse_lane6", lane, 16'hFFDC);
    lane = got[5*OW +: OW];         chk("sparse_lane5", lane, 16'h0000);
    lane = got[30*OW +: OW];        chk("sparse_lane30", lane, 16'hFF4C);

    run_job(1, 0, 0, 5, "stall_k1", got);

    run_job(2, 3, 0, 0, "narrow_k2", got);
    lane = got[0 +: OW];
`ifdef MAC_LANE_SAT_EN
    chk("narrow_lane0", lane, 16'h7FFF);
`else
    chk("narrow_lane0", lane, 16'h0002);
`endif

    // Interrupt a 4-beat job after two beats; reset wins over a live beat.
    cfg_k = 4'd4;
    for (int bt = 0; bt < 2; bt++) begin
      fill(0);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_acc_busy", busy, 1);
    rst = 1'b1;
    fill(0);
    @(posedge clk); #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk_vec("mid_rst_data", out_data, '0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_valid", out_valid, 0);
    chk("after_rst_busy", busy, 0);
    chk_vec("after_rst_data", out_data, '0);
    run_job(2, 0, 1, 0, "post_rst_k2", got);

    run_job(0, 0, 0, 1, "cfg0", got);
    run_job(12, 0, 1, 0, "clamp12", got);
    run_job(3, 0, 2, 2, "cfg_change", got);

    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 15), 0, $urandom_range(0, 2), $urandom_range(0, 2), "rand", got);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_lane_array.md
MAC_LANE_ARRAY -- requirements
Module: mac_lane_array

Interface
REQ-001 SHALL have parameter LANES, default 32, giving the number of independent MAC lanes.
REQ-002 SHALL have parameter DATA_W, default 16, giving the signed operand width per lane.
REQ-003 SHALL have parameter ACC_W, default 40, giving the signed accumulator width per lane; ACC_W >= 2*DATA_W.
REQ-004 SHALL have parameter OUT_W, default 32, giving the signed result width per lane; OUT_W <= ACC_W.
REQ-005 SHALL have parameter K_MAX, default 256, giving the maximum number of beats per dot product.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port cfg_k, input, $clog2(K_MAX+1) bits: beats per dot product, sampled on the first beat of a job.
REQ-009 SHALL have port in_valid, input, 1 bit: operand beat valid.
REQ-010 SHALL have port in_ready, output, 1 bit: operand beat accepted when in_valid && in_ready.
REQ-011 SHALL have port in_a, input, LANES*DATA_W bits: lane i occupies bits [i*DATA_W +: DATA_W], signed.
REQ-012 SHALL have port in_b, input, LANES*DATA_W bits: same packing as in_a.
REQ-013 SHALL have port in_mask, input, LANES bits: 1 = lane product is used; 0 = lane is sparse-skipped for this beat.
REQ-014 SHALL have port out_valid, output, 1 bit: result vector valid.
REQ-015 SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-016 SHALL have port out_data, output, LANES*OUT_W bits: lane i at [i*OUT_W +: OUT_W], signed.
REQ-017 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, ACC and DRAIN.
REQ-019 In IDLE, in_ready SHALL be 1; an accepted beat SHALL latch k = (cfg_k==0 ? 1 : min(cfg_k, K_MAX)), overwrite every accumulator lane with that beat's product, set beat count to 1, and move to ACC, or directly to DRAIN if k==1.
REQ-020 In ACC, in_ready SHALL be 1; each accepted beat SHALL add its lane products to the accumulators and increment the beat count; the k-th beat SHALL move the FSM to DRAIN.
REQ-021 A cycle with in_valid=0 in ACC SHALL leave the accumulators and beat count unchanged.
REQ-022 Each lane product SHALL be the full-precision signed a*b (2*DATA_W bits), sign-extended to ACC_W; a lane with in_mask[i]=0 SHALL contribute 0.
REQ-023 Accumulator addition SHALL be ACC_W-bit two's-complement with wrap-around.
REQ-024 In DRAIN, out_valid SHALL be 1, in_ready SHALL be 0, and out_data SHALL hold each lane narrowed per REQ-032/REQ-033, stable until the result is accepted.
REQ-025 Latency: out_valid SHALL rise on the clock edge that accepts the k-th beat, i.e. it is visible in the first cycle after that beat.
REQ-026 A DRAIN cycle with out_valid && out_ready SHALL return the FSM to IDLE, and in_ready SHALL be 1 in the next cycle; the same cycle SHALL NOT accept an input beat.
REQ-027 cfg_k changes after the first beat SHALL NOT affect the job in progress.

Reset
REQ-028 When rst=1 at a clock edge, the FSM SHALL enter IDLE and the beat count and all accumulators SHALL clear to 0.
REQ-029 Output values during reset and in the following cycle SHALL be: out_valid=0, out_data=0, busy=0, in_ready=1.
REQ-030 Reset SHALL take priority over any simultaneous handshake; a job interrupted by reset SHALL be discarded with no output.
REQ-031 In IDLE, out_data SHALL read 0.

Configuration
REQ-032 With macro MAC_LANE_SAT_EN defined, narrowing SHALL saturate each lane to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-033 Without MAC_LANE_SAT_EN, narrowing SHALL take the low OUT_W bits of the accumulator (wrap).

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- LANES=32, cfg_k=4, all a=b=1, mask all 1, out_ready=1 -> out_valid one cycle after beat 4, each lane = 4, back to IDLE the next cycle.
- cfg_k=3, lane i a=i, b=-2, mask alternating 1010..., in_valid gaps -> lane i = -6*i on even lanes, 0 on odd lanes; gaps do not add beats.
- cfg_k=1, out_ready held 0 for 5 cycles -> out_valid stays 1 with stable data and in_ready=0; the handshake then completes and the block goes to IDLE.
- OUT_W=16, cfg_k=2, a=b=32767 -> 0x7FFF with MAC_LANE_SAT_EN; 0x0002 (low 16 bits of 2147352578) without it.
- rst asserted mid-ACC after 2 of 4 beats -> outputs match REQ-029; a new cfg_k=2 job then yields only its own sums.
- cfg_k=0 -> behaves as k=1; cfg_k changed mid-job -> the original k is honoured.
